regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg) between
//  the pipeline writeback stage (priority) and the multi-cycle mult/div unit. A 1-entry holding buffer
//  parks a mult/div result until a free write slot. Starvation guard stalls the pipeline to drain it.
//  Buffered value is bypassed to both read ports so readers never see a stale register.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register address width (32 registers, r0 hardwired zero)
//  MAX_WAIT  4   cycles a buffered result may wait before the pipeline is stalled (1..15)
// PORTS
//  clock            in   1       single clock, all state on rising edge
//  ctrl_reset       in   1       asynchronous, active-high reset
//  p_we             in   1       pipeline writeback request this cycle
//  p_reg            in   ADDR_W  pipeline destination register
//  p_data           in   DATA_W  pipeline writeback data
//  m_valid          in   1       mult/div result valid
//  m_ready          out  1       arbiter can accept mult/div result
//  m_reg            in   ADDR_W  mult/div destination register
//  m_data           in   DATA_W  mult/div result
//  stall_pipe       out  1       pipeline must freeze its WB stage this cycle
//  ctrl_writeEnable out  1       to register file write port
//  ctrl_writeReg    out  ADDR_W  to register file write port
//  data_writeReg    out  DATA_W  to register file write port
//  ctrl_readRegA/B  in   ADDR_W  read addresses presented to register file
//  byp_hitA/B       out  1       buffered value overrides register file read A/B
//  byp_data         out  DATA_W  buffered value (valid when byp_hitA or byp_hitB)
// BEHAVIOUR
//  - State: buf_valid, buf_reg, buf_data, wait_cnt, FSM {IDLE, HOLD, FORCE}. Reset: IDLE, buf_valid=0,
//    wait_cnt=0, buf_reg/buf_data=0. While ctrl_reset high: m_ready=0, stall_pipe=0, ctrl_writeEnable=0.
//  - Outputs are combinational from state + inputs; regfile commits on the same rising edge (0 latency).
//  - m_ready = !buf_valid (no same-cycle drain-and-refill). Capture on m_valid&&m_ready.
//  - Write select, in order: FORCE -> buffer; else p_we&&p_reg!=0 -> pipeline;
//    else buf_valid -> buffer; else ctrl_writeEnable=0. Writes to r0 never assert ctrl_writeEnable.
//  - Capture with m_reg==0: handshake completes, result discarded, buffer stays empty.
//  - Capture cycle with no pipeline write: result goes straight to port (pass-through), buffer stays empty.
//  - IDLE->HOLD when result buffered; HOLD->IDLE when buffer written or dropped.
//  - wait_cnt increments each HOLD cycle without drain; when wait_cnt==MAX_WAIT-1 and not drained
//    -> FORCE next cycle. FORCE: stall_pipe=1, buffer written, p_we ignored (pipeline re-presents it
//    next cycle), -> IDLE, wait_cnt=0. FORCE lasts exactly one cycle.
//  - WAW: p_we with p_reg==buf_reg while buf_valid (not FORCE) -> pipeline writes, buffer dropped
//    (buf_valid=0, wait_cnt=0, ->IDLE). Same-cycle capture to same reg as p write: capture kept.
//  - Bypass: byp_hitA = buf_valid && ctrl_readRegA==buf_reg && ctrl_readRegA!=0; same for B.
//  - Reset mid-HOLD/FORCE: buffered result lost, state to IDLE immediately (asynchronous).
// TESTING
//  - Reset then m_valid, m_reg=5, m_data=0xA5, p_we=0 -> same cycle write r5=0xA5, m_ready stays 1.
//  - p_we r3=0x11 with m_valid r7=0x22 -> r3 written; next cycle (p_we=0) r7=0x22 written, m_ready 0 for 1 cycle.
//  - Buffer r7 held, p_we every cycle to r1..r4 -> stall_pipe=1 in 5th cycle, r7 written, p_we ignored there.
//  - Buffer r9=0x33, p_we r9=0x44 -> r9=0x44, buffer dropped, never written later; byp_hitA=0 after.
//  - Buffer r6=0x77, ctrl_readRegA=6, ctrl_readRegB=0 -> byp_hitA=1, byp_hitB=0, byp_data=0x77.
//  - m_valid m_reg=0 -> no write; ctrl_reset pulse during HOLD -> buf_valid=0, m_ready=1 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates the register file's single write port between the pipeline
// writeback stage (priority) and the multi-cycle mult/div unit. A one-entry
// buffer parks a mult/div result that lost arbitration. If it waits too long,
// the pipeline is stalled for one cycle to drain it. The buffered value is
// bypassed to both read ports, so readers never see a stale register.
//
// Ports
//   clock, ctrl_reset           clock, asynchronous active-high reset
//   p_we/p_reg/p_data           pipeline writeback request
//   m_valid/m_ready/m_reg/m_data mult/div result handshake
//   stall_pipe                  freeze pipeline WB stage this cycle
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  register file write port
//   ctrl_readRegA/B             register file read addresses
//   byp_hitA/B, byp_data        buffered value overrides read A/B
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_reg,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_reg,
  input  logic [DATA_W-1:0] m_data,
  output logic              stall_pipe,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic              byp_hitA,
  output logic              byp_hitB,
  output logic [DATA_W-1:0] byp_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0]        WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] REG_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            r_state, w_state_nxt;
  logic              r_buf_valid, w_buf_valid_nxt;
  logic [ADDR_W-1:0] r_buf_reg, w_buf_reg_nxt;
  logic [DATA_W-1:0] r_buf_data, w_buf_data_nxt;
  logic [3:0]        r_wait_cnt, w_wait_cnt_nxt;

  logic w_p_wr;
  logic w_m_ready;
  logic w_cap_live;

  // Writes to r0 are architecturally void, so they never count as a write.
  assign w_p_wr     = p_we && (p_reg != REG_ZERO);
  // No same-cycle drain-and-refill: accept only into an empty buffer.
  assign w_m_ready  = !r_buf_valid && !ctrl_reset;
  assign w_cap_live = m_valid && w_m_ready && (m_reg != REG_ZERO);
  assign m_ready    = w_m_ready;

  // State register and holding buffer.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_reg   <= REG_ZERO;
      r_buf_data  <= DATA_ZERO;
      r_wait_cnt  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_reg   <= w_buf_reg_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic: buffer fill, drain, WAW drop and starvation timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_reg_nxt   = r_buf_reg;
    w_buf_data_nxt  = r_buf_data;
    w_wait_cnt_nxt  = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        // Only park the result when the pipeline owns the port this cycle;
        // otherwise it passes straight through to the register file.
        if (w_cap_live && w_p_wr) begin
          w_state_nxt     = ST_HOLD;
          w_buf_valid_nxt = 1'b1;
          w_buf_reg_nxt   = m_reg;
          w_buf_data_nxt  = m_data;
          w_wait_cnt_nxt  = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_p_wr && (p_reg == r_buf_reg)) begin
          // Younger pipeline write supersedes the parked result.
          w_state_nxt     = ST_IDLE;
          w_buf_valid_nxt = 1'b0;
          w_wait_cnt_nxt  = 4'd0;
        end else if (w_p_wr) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ST_FORCE;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          end
        end else begin
          // Free slot: buffer drains this cycle.
          w_state_nxt     = ST_IDLE;
          w_buf_valid_nxt = 1'b0;
          w_wait_cnt_nxt  = 4'd0;
        end
      end
      ST_FORCE: begin
        w_state_nxt     = ST_IDLE;
        w_buf_valid_nxt = 1'b0;
        w_wait_cnt_nxt  = 4'd0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_buf_valid_nxt = 1'b0;
        w_wait_cnt_nxt  = 4'd0;
      end
    endcase
  end

  // Write port select, stall and read bypass outputs.
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = REG_ZERO;
    data_writeReg    = DATA_ZERO;
    stall_pipe       = 1'b0;
    if (ctrl_reset) begin
      ctrl_writeEnable = 1'b0;
    end else if (r_state == ST_FORCE) begin
      // Pipeline request is ignored; it re-presents it next cycle.
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = r_buf_reg;
      data_writeReg    = r_buf_data;
      stall_pipe       = 1'b1;
    end else if (w_p_wr) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = p_reg;
      data_writeReg    = p_data;
    end else if (r_buf_valid) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = r_buf_reg;
      data_writeReg    = r_buf_data;
    end else if (w_cap_live) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = m_reg;
      data_writeReg    = m_data;
    end else begin
      ctrl_writeEnable = 1'b0;
    end

    byp_hitA = r_buf_valid && (ctrl_readRegA == r_buf_reg) && (ctrl_readRegA != REG_ZERO);
    byp_hitB = r_buf_valid && (ctrl_readRegB == r_buf_reg) && (ctrl_readRegB != REG_ZERO);
    byp_data = r_buf_data;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic              p_we;
  logic [ADDR_W-1:0] p_reg;
  logic [DATA_W-1:0] p_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic              stall_pipe;
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic              byp_hitA;
  logic              byp_hitB;
  logic [DATA_W-1:0] byp_data;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .p_we(p_we), .p_reg(p_reg), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
    .stall_pipe(stall_pipe),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .byp_hitA(byp_hitA), .byp_hitB(byp_hitB), .byp_data(byp_data)
  );

  always #5 clock = ~clock;

  // Scoreboard: every register file write must match the next expected write.
  always @(negedge clock) begin
    if (!ctrl_reset && ctrl_writeEnable) begin
      logic [ADDR_W+DATA_W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got write r%0d=%h, required no write", ctrl_writeReg, data_writeReg);
      end else begin
        e = exp_q.pop_front();
        if ({ctrl_writeReg, data_writeReg} !== e) begin
          errors++;
          $display("FAIL sb_write: got r%0d=%h, required r%0d=%h",
                   ctrl_writeReg, data_writeReg, e[DATA_W+ADDR_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p_we = 1'b0; p_reg = 5'd0; p_data = 32'd0;
    m_valid = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    p_we = 1'b1; p_reg = 5'd3; p_data = 32'h1;
    m_valid = 1'b1; m_reg = 5'd4; m_data = 32'h2;
    @(negedge clock);
    checks++;
    if ({m_ready, stall_pipe, ctrl_writeEnable, byp_hitA} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/stall/we/hit=%b, required 0000",
               {m_ready, stall_pipe, ctrl_writeEnable, byp_hitA});
    end
    tick();
    ctrl_reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1 || ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got m_ready=%b we=%b, required 1 0", m_ready, ctrl_writeEnable);
    end
    tick();
  endtask

  task automatic test_passthrough();
    m_valid = 1'b1; m_reg = 5'd5; m_data = 32'hA5;
    push_exp(5'd5, 32'hA5);
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL pass_ready: got %b, required 1", m_ready);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pass_after: got m_ready=%b pending=%0d, required 1 0", m_ready, exp_q.size());
    end
    tick();
  endtask

  task automatic test_buffer();
    p_we = 1'b1; p_reg = 5'd3; p_data = 32'h11;
    m_valid = 1'b1; m_reg = 5'd7; m_data = 32'h22;
    push_exp(5'd3, 32'h11);
    tick();
    idle_inputs();
    push_exp(5'd7, 32'h22);
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b0) begin
      errors++;
      $display("FAIL buf_ready_low: got %b, required 0", m_ready);
    end
    tick();
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL buf_drain: got m_ready=%b pending=%0d, required 1 0", m_ready, exp_q.size());
    end
    tick();
  endtask

  task automatic test_force();
    p_we = 1'b1; p_reg = 5'd8; p_data = 32'h80;
    m_valid = 1'b1; m_reg = 5'd7; m_data = 32'h70;
    push_exp(5'd8, 32'h80);
    tick();
    m_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      p_reg = 5'(i); p_data = 32'(i);
      push_exp(5'(i), 32'(i));
      @(negedge clock);
      checks++;
      if (stall_pipe !== 1'b0) begin
        errors++;
        $display("FAIL force_early_%0d: got stall=%b, required 0", i, stall_pipe);
      end
      tick();
    end
    p_reg = 5'd5; p_data = 32'h55;
    push_exp(5'd7, 32'h70);
    @(negedge clock);
    checks++;
    if (stall_pipe !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL force_stall: got stall=%b m_ready=%b, required 1 0", stall_pipe, m_ready);
    end
    tick();
    push_exp(5'd5, 32'h55);
    @(negedge clock);
    checks++;
    if (stall_pipe !== 1'b0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL force_after: got stall=%b m_ready=%b, required 0 1", stall_pipe, m_ready);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL force_pending: got %0d, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_waw();
    p_we = 1'b1; p_reg = 5'd2; p_data = 32'h20;
    m_valid = 1'b1; m_reg = 5'd9; m_data = 32'h33;
    push_exp(5'd2, 32'h20);
    tick();
    m_valid = 1'b0;
    p_reg = 5'd9; p_data = 32'h44; ctrl_readRegA = 5'd9;
    push_exp(5'd9, 32'h44);
    @(negedge clock);
    checks++;
    if (byp_hitA !== 1'b1) begin
      errors++;
      $display("FAIL waw_hit_before: got %b, required 1", byp_hitA);
    end
    tick();
    p_we = 1'b0;
    @(negedge clock);
    checks++;
    if (byp_hitA !== 1'b0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_dropped: got hitA=%b m_ready=%b, required 0 1", byp_hitA, m_ready);
    end
    for (int i = 0; i < 6; i++) tick();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL waw_pending: got %0d, required 0", exp_q.size());
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    p_we = 1'b1; p_reg = 5'd1; p_data = 32'h10;
    m_valid = 1'b1; m_reg = 5'd6; m_data = 32'h77;
    push_exp(5'd1, 32'h10);
    tick();
    m_valid = 1'b0;
    p_reg = 5'd2; p_data = 32'h21;
    ctrl_readRegA = 5'd6; ctrl_readRegB = 5'd0;
    push_exp(5'd2, 32'h21);
    @(negedge clock);
    checks++;
    if (byp_hitA !== 1'b1 || byp_hitB !== 1'b0 || byp_data !== 32'h77) begin
      errors++;
      $display("FAIL byp_a: got hitA=%b hitB=%b data=%h, required 1 0 00000077", byp_hitA, byp_hitB, byp_data);
    end
    tick();
    p_we = 1'b0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd6;
    push_exp(5'd6, 32'h77);
    @(negedge clock);
    checks++;
    if (byp_hitA !== 1'b0 || byp_hitB !== 1'b1) begin
      errors++;
      $display("FAIL byp_b: got hitA=%b hitB=%b, required 0 1", byp_hitA, byp_hitB);
    end
    tick();
    @(negedge clock);
    checks++;
    if (byp_hitB !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL byp_after: got hitB=%b pending=%0d, required 0 0", byp_hitB, exp_q.size());
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_reg();
    p_we = 1'b1; p_reg = 5'd10; p_data = 32'h0A;
    m_valid = 1'b1; m_reg = 5'd10; m_data = 32'h0B;
    push_exp(5'd10, 32'h0A);
    tick();
    idle_inputs();
    push_exp(5'd10, 32'h0B);
    tick();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL same_reg_pending: got %0d, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_r0();
    m_valid = 1'b1; m_reg = 5'd0; m_data = 32'hFF;
    @(negedge clock);
    checks++;
    if (ctrl_writeEnable !== 1'b0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_result: got we=%b m_ready=%b, required 0 1", ctrl_writeEnable, m_ready);
    end
    tick();
    p_we = 1'b1; p_reg = 5'd0; p_data = 32'h12;
    m_reg = 5'd4; m_data = 32'h44;
    push_exp(5'd4, 32'h44);
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: got %b, required 1", m_ready);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL r0_after: got m_ready=%b pending=%0d, required 1 0", m_ready, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_hold();
    p_we = 1'b1; p_reg = 5'd1; p_data = 32'h01;
    m_valid = 1'b1; m_reg = 5'd12; m_data = 32'hCC;
    push_exp(5'd1, 32'h01);
    tick();
    m_valid = 1'b0;
    p_reg = 5'd2; p_data = 32'h02; ctrl_readRegA = 5'd12;
    #2;
    ctrl_reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ctrl_writeEnable, m_ready, stall_pipe, byp_hitA} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_hold_during: got we/rdy/stall/hit=%b, required 0000",
               {ctrl_writeEnable, m_ready, stall_pipe, byp_hitA});
    end
    tick();
    ctrl_reset = 1'b0;
    p_we = 1'b0;
    @(negedge clock);
    checks++;
    if (m_ready !== 1'b1 || byp_hitA !== 1'b0 || ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_after: got m_ready=%b hitA=%b we=%b, required 1 0 0",
               m_ready, byp_hitA, ctrl_writeEnable);
    end
    for (int i = 0; i < 4; i++) tick();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_hold_pending: got %0d, required 0", exp_q.size());
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    ctrl_reset = 1'b1;
    #1;
    test_reset();
    test_passthrough();
    test_buffer();
    test_force();
    test_waw();
    test_bypass();
    test_same_reg();
    test_r0();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
